// File: rtl/vote_tally_regfile_if.sv
// Ballot-side and display-side signal bundle for vote_tally_regfile.
// The slave modport is the tally block; the master modport is its environment.
interface vote_tally_regfile_if #(
    parameter int SEL_W = 2,
    parameter int CNT_W = 8,
    parameter int TOT_W = 10
);
    logic             open_poll;
    logic             close_poll;
    logic             cast_valid;
    logic [SEL_W-1:0] cast_sel;
    logic             cast_ready;
    logic [SEL_W-1:0] rd_addr;
    logic [CNT_W-1:0] rd_data;
    logic [TOT_W-1:0] total_votes;
    logic [1:0]       poll_state;
    logic             sat_flag;
    logic             bad_sel;

    modport master (
        output open_poll, close_poll, cast_valid, cast_sel, rd_addr,
        input  cast_ready, rd_data, total_votes, poll_state, sat_flag, bad_sel
    );

    modport slave (
        input  open_poll, close_poll, cast_valid, cast_sel, rd_addr,
        output cast_ready, rd_data, total_votes, poll_state, sat_flag, bad_sel
    );
endinterface

// File: rtl/vote_tally_regfile.sv
// Per-candidate saturating vote counters with poll sequencing (IDLE/OPEN/CLOSED),
// one-vote-per-two-cycles acceptance and a registered read port.
module vote_tally_regfile #(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8,
    parameter int SEL_W    = 2,
    parameter int TOT_W    = 10
) (
    input logic                clk,
    input logic                rst,
    vote_tally_regfile_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_OPEN   = 2'b01,
        ST_CLOSED = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [SEL_W:0]   NUM_CAND_EXT = (SEL_W+1)'(NUM_CAND);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic at_max(input logic [CNT_W-1:0] v);
        return v == CNT_MAX;
    endfunction

    state_t           state_q, state_d;
    logic             lock_q, lock_d;
    logic [CNT_W-1:0] cnt_q [NUM_CAND];
    logic [CNT_W-1:0] cnt_d [NUM_CAND];
    logic [TOT_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic             sat_q, sat_d;
    logic             bad_q, bad_d;

    logic             cast_ready;
    logic             accept;
    logic             sel_ok;
    logic [CNT_W-1:0] sel_cnt;

    always_comb begin
        cast_ready = (state_q == ST_OPEN) && !lock_q;
        // close_poll wins over a same-cycle cast, so the vote is never seen
        accept     = bus.cast_valid && cast_ready && !bus.close_poll;
        sel_ok     = {1'b0, bus.cast_sel} < NUM_CAND_EXT;

        sel_cnt   = '0;
        rd_data_d = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (bus.cast_sel == SEL_W'(i)) sel_cnt   = cnt_q[i];
            if (bus.rd_addr  == SEL_W'(i)) rd_data_d = cnt_q[i];
        end

        state_d = state_q;
        lock_d  = 1'b0;
        cnt_d   = cnt_q;
        total_d = total_q;
        sat_d   = sat_q;
        bad_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.open_poll) begin
                    state_d = ST_OPEN;
                    for (int i = 0; i < NUM_CAND; i++) cnt_d[i] = '0;
                    total_d = '0;
                    sat_d   = 1'b0;
                end
            end
            ST_OPEN: begin
                if (bus.close_poll) begin
                    state_d = ST_CLOSED;
                end else if (accept) begin
                    lock_d = 1'b1;
                    if (!sel_ok) begin
                        bad_d = 1'b1;
                    end else if (at_max(sel_cnt)) begin
                        sat_d = 1'b1;
                    end else begin
                        for (int i = 0; i < NUM_CAND; i++)
                            if (bus.cast_sel == SEL_W'(i)) cnt_d[i] = sat_inc(cnt_q[i]);
                        // total cannot overflow: TOT_W covers NUM_CAND full counters
                        total_d = total_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            lock_q    <= 1'b0;
            for (int i = 0; i < NUM_CAND; i++) cnt_q[i] <= '0;
            total_q   <= '0;
            rd_data_q <= '0;
            sat_q     <= 1'b0;
            bad_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lock_q    <= lock_d;
            cnt_q     <= cnt_d;
            total_q   <= total_d;
            rd_data_q <= rd_data_d;
            sat_q     <= sat_d;
            bad_q     <= bad_d;
        end
    end

    assign bus.cast_ready  = cast_ready;
    assign bus.rd_data     = rd_data_q;
    assign bus.total_votes = total_q;
    assign bus.poll_state  = state_q;
    assign bus.sat_flag    = sat_q;
    assign bus.bad_sel     = bad_q;
endmodule
